// File: rtl/adder_subtractor_pkg.sv
// Shared types, defaults and flag helpers for the pipelined adder/subtractor.
package adder_subtractor_pkg;

  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CHUNK = 16;

  // Signed overflow: both addends share a sign that the sum does not.
  function automatic logic signed_overflow(logic a_msb, logic b_msb, logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_subtractor_stage.sv
// One CHUNK-bit carry-propagate slice; purely combinational.
module adder_subtractor_stage #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_subtractor_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, with a
// globally stalled valid/ready handshake and carry/overflow/zero flags.
module adder_subtractor_pipe
  import adder_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned Stages = WIDTH / CHUNK;
  localparam int unsigned Last = Stages - 1;
  localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gen_param_check
    $error("adder_subtractor_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Operands are kept full width in the skew registers; lower chunks that are
  // already consumed are dead and get trimmed by synthesis.
  logic [Stages-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [Stages-1:0]            carry_q, valid_q;
  logic                         overflow_q, zero_q;

  logic [Stages-1:0][WIDTH-1:0] a_in, b_in, s_in, sum_d;
  logic [Stages-1:0][CHUNK-1:0] st_sum;
  logic [Stages-1:0]            c_in, carry_d;
  logic [WIDTH-1:0]             b_eff;
  logic                         cin0, adv, overflow_d, zero_d;

  assign cin0  = (mode_e'(mode) == MODE_SUB);
  assign b_eff = op2 ^ {WIDTH{cin0}};

  assign out_valid = valid_q[Last];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < Stages; k++) begin : gen_stage
    if (k == 0) begin : gen_first
      assign a_in[k] = op1;
      assign b_in[k] = b_eff;
      assign s_in[k] = '0;
      assign c_in[k] = cin0;
    end else begin : gen_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = sum_q[k-1];
      assign c_in[k] = carry_q[k-1];
    end

    adder_subtractor_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .a   (a_in[k][k*CHUNK +: CHUNK]),
      .b   (b_in[k][k*CHUNK +: CHUNK]),
      .cin (c_in[k]),
      .sum (st_sum[k]),
      .cout(carry_d[k])
    );

    // Splice this stage's chunk into the partial sum carried from upstream.
    assign sum_d[k] = (s_in[k] & ~(ChunkMask << (k * CHUNK)))
                    | (WIDTH'(st_sum[k]) << (k * CHUNK));
  end

  assign overflow_d = signed_overflow(a_in[Last][WIDTH-1], b_in[Last][WIDTH-1],
                                      sum_d[Last][WIDTH-1]);
  assign zero_d     = (sum_d[Last] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (adv) begin
      a_q        <= a_in;
      b_q        <= b_in;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      valid_q[0] <= in_valid && in_ready;
      for (int unsigned k = 1; k < Stages; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign result    = sum_q[Last];
  assign carry_out = carry_q[Last];
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  logic unused_opnd;
  assign unused_opnd = ^{a_in, b_in, a_q[Last], b_q[Last]};

endmodule

// File: tb/tb_adder_subtractor_pipe.sv
// Directed and randomised bench for adder_subtractor_pipe (WIDTH=64, CHUNK=16).
module tb_adder_subtractor_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, mode;
  logic [63:0] op1, op2, result;
  logic        out_valid, out_ready, carry_out, overflow, zero;

  int errors;
  int checks;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    logic [63:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  adder_subtractor_pipe #(
    .WIDTH(64),
    .CHUNK(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat into an idle pipe and wait (bounded) for its result.
  task automatic issue_and_wait(input logic [63:0] a, input logic [63:0] b, input logic m,
                                output int lat, output logic [63:0] r,
                                output logic c, output logic o, output logic z);
    @(negedge clk);
    op1 = a; op2 = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r = result; c = carry_out; o = overflow; z = zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({result, carry_out, overflow, zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_data: got r=%h c=%b o=%b z=%b want all 0",
               result, carry_out, overflow, zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_carry();
    int lat; logic [63:0] r; logic c, o, z;
    issue_and_wait(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, lat, r, c, o, z);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL add_carry_latency: got %0d want 4", lat);
    end
    checks++;
    if ({r, c, o, z} !== {64'h0000_0000_0001_0000, 3'b000}) begin
      errors++;
      $display("FAIL add_carry: got r=%h c=%b o=%b z=%b want r=0000000000010000 c=0 o=0 z=0",
               r, c, o, z);
    end
  endtask

  task automatic test_sub_zero();
    int lat; logic [63:0] r; logic c, o, z;
    issue_and_wait(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, lat, r, c, o, z);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL sub_zero_latency: got %0d want 4", lat);
    end
    checks++;
    if ({r, c, o, z} !== {64'd0, 3'b101}) begin
      errors++;
      $display("FAIL sub_zero: got r=%h c=%b o=%b z=%b want r=0 c=1 o=0 z=1", r, c, o, z);
    end
  endtask

  task automatic test_wrap_overflow();
    vec_t tbl [4];
    int lat; logic [63:0] r; logic c, o, z;
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue_and_wait(tbl[i].a, tbl[i].b, tbl[i].m, lat, r, c, o, z);
      checks++;
      if (lat !== 4 || {r, c, o, z} !== {tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].z}) begin
        errors++;
        $display("FAIL wrap_%0d: got lat=%0d r=%h c=%b o=%b z=%b want lat=4 r=%h c=%b o=%b z=%b",
                 i, lat, r, c, o, z, tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [63:0] exp_r;
    out_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; mode = 1'b0;
        op1 = 64'(cyc) * 64'h0000_0000_0001_0001;
        op2 = 64'h0000_0001_0000_0000;
      end else begin
        in_valid = 1'b0;
      end
      exp_v = (cyc >= 4) && (cyc < 12);
      exp_r = 64'(cyc - 4) * 64'h0000_0000_0001_0001 + 64'h0000_0001_0000_0000;
      #1;
      checks++;
      if (out_valid !== exp_v || (exp_v && result !== exp_r)) begin
        errors++;
        $display("FAIL b2b_cycle_%0d: got v=%b r=%h want v=%b r=%h",
                 cyc, out_valid, result, exp_v, exp_r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_q [$];
    logic [63:0] held_r;
    logic        held;
    int          sent, got;
    sent = 0; got = 0; held = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        in_valid = 1'b1; mode = 1'b0;
        op1 = 64'(sent) * 64'h10; op2 = 64'h3;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || result !== held_r) begin
          errors++;
          $display("FAIL bp_hold_%0d: got v=%b r=%h want v=1 r=%h", cyc, out_valid, result, held_r);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", cyc, in_ready);
        end
        held = 1'b1; held_r = result;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || result !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_order_%0d: got r=%h want %h", got, result,
                   (exp_q.size() == 0) ? 64'hx : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(op1 + op2);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d results, %0d pending; want 8 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic stale;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; mode = 1'b0; op1 = 64'h5 + 64'(i); op2 = 64'h3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 64'h8) begin
      errors++; $display("FAIL rst_mid_pre: got v=%b r=%h want v=1 r=8", out_valid, result);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, carry_out, overflow, zero} !== 68'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: got v=%b r=%h c=%b o=%b z=%b want all 0",
               out_valid, result, carry_out, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
    end
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stale: got out_valid after reset, want none");
    end
  endtask

  task automatic test_random();
    logic [66:0] exp_q [$];
    logic [66:0] exp;
    logic [64:0] full;
    logic [63:0] beff, held_r;
    logic        held;
    int          sent, got;
    sent = 0; got = 0; held = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!(in_valid && !in_ready)) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        op1  = {$urandom(), $urandom()};
        op2  = ($urandom_range(0, 7) == 0) ? op1 : {$urandom(), $urandom()};
        mode = $urandom_range(0, 1) == 1;
      end
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || result !== held_r) begin
          errors++;
          $display("FAIL rnd_hold_%0d: got v=%b r=%h want v=1 r=%h", cyc, out_valid, result, held_r);
        end
      end
      held = out_valid && !out_ready;
      held_r = result;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || {carry_out, overflow, zero, result} !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_beat_%0d: got c=%b o=%b z=%b r=%h want {c,o,z,r}=%h",
                   got, carry_out, overflow, zero, result,
                   (exp_q.size() == 0) ? 67'hx : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        beff = mode ? ~op2 : op2;
        full = {1'b0, op1} + {1'b0, beff} + {64'd0, mode};
        exp = {full[64], (op1[63] == beff[63]) && (full[63] != op1[63]),
               full[63:0] == 64'd0, full[63:0]};
        exp_q.push_back(exp);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_count: got %0d results, %0d pending; want 10000 and 0",
               got, exp_q.size());
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    op1 = '0; op2 = '0;
    test_reset();
    test_add_carry();
    test_sub_zero();
    test_wrap_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
